// File: rtl/keycode_direction_filter_if.sv
// Keycode/frame inputs and direction/walk outputs between the SoC keycode
// register, the direction filter and the movement stage.
interface keycode_direction_filter_if;
  logic [7:0] keycode;
  logic       frame_vs;
  logic       step_busy;
  logic [1:0] direction;
  logic       walk_req;
  logic       turn_pulse;
  logic       key_valid;

  modport master (
    output keycode, frame_vs, step_busy,
    input  direction, walk_req, turn_pulse, key_valid
  );

  modport slave (
    input  keycode, frame_vs, step_busy,
    output direction, walk_req, turn_pulse, key_valid
  );
endinterface

// File: rtl/keycode_direction_filter.sv
// Once-per-frame W/A/S/D decoder with tap-to-turn / hold-to-walk behaviour;
// direction is frozen while the movement stage reports a step in progress.
module keycode_direction_filter #(
  parameter int unsigned HOLD_FRAMES = 3,
  parameter logic [7:0]  KEY_UP      = 8'h1A,
  parameter logic [7:0]  KEY_LEFT    = 8'h04,
  parameter logic [7:0]  KEY_DOWN    = 8'h16,
  parameter logic [7:0]  KEY_RIGHT   = 8'h07
) (
  input logic                      Clk,
  input logic                      Reset_n,
  keycode_direction_filter_if.slave kif
);

  typedef enum logic [1:0] {IDLE, TURN, WALK} state_t;

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam logic [3:0] HOLD_LIM  = 4'(HOLD_FRAMES);

  logic       rst_meta, rst_n_int;
  logic       vs_s1, vs_s2, vs_s3;
  logic       tick, eval;
  logic       key_valid_q;
  logic [1:0] kdir;
  logic       dec_valid;
  logic [1:0] dec_dir;
  state_t     state;
  logic [1:0] dir_q;
  logic       walk_q, turn_q;
  logic [3:0] hold_cnt, cnt_inc;

  // Reset asserts immediately, releases on the second clock edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_meta  <= 1'b0;
      rst_n_int <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_n_int <= rst_meta;
    end
  end

  always_comb begin
    dec_valid = 1'b1;
    dec_dir   = DIR_DOWN;
    case (kif.keycode)
      KEY_UP:    dec_dir = DIR_UP;
      KEY_LEFT:  dec_dir = DIR_LEFT;
      KEY_DOWN:  dec_dir = DIR_DOWN;
      KEY_RIGHT: dec_dir = DIR_RIGHT;
      default:   dec_valid = 1'b0;
    endcase
  end

  // tick fires three clocks after the VS pin rises; eval follows one clock later
  always_ff @(posedge Clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      vs_s1       <= 1'b1;
      vs_s2       <= 1'b1;
      vs_s3       <= 1'b1;
      tick        <= 1'b0;
      eval        <= 1'b0;
      key_valid_q <= 1'b0;
      kdir        <= DIR_DOWN;
    end else begin
      vs_s1 <= kif.frame_vs;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
      tick  <= vs_s2 & ~vs_s3;
      eval  <= tick;
      if (tick) begin
        key_valid_q <= dec_valid;
        kdir        <= dec_dir;
      end
    end
  end

  assign cnt_inc = (hold_cnt == 4'hF) ? hold_cnt : hold_cnt + 4'd1;

  always_ff @(posedge Clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state    <= IDLE;
      dir_q    <= DIR_DOWN;
      walk_q   <= 1'b0;
      turn_q   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      turn_q <= 1'b0;
      if (eval) begin
        case (state)
          IDLE: begin
            if (key_valid_q) begin
              if (kdir == dir_q) begin
                state  <= WALK;
                walk_q <= 1'b1;
              end else begin
                dir_q    <= kdir;
                turn_q   <= 1'b1;
                hold_cnt <= 4'd1;
                state    <= TURN;
              end
            end
          end
          TURN: begin
            if (!key_valid_q) begin
              state    <= IDLE;
              hold_cnt <= '0;
            end else if (kdir != dir_q) begin
              dir_q    <= kdir;
              turn_q   <= 1'b1;
              hold_cnt <= 4'd1;
            end else if (cnt_inc >= HOLD_LIM) begin
              state    <= WALK;
              walk_q   <= 1'b1;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= cnt_inc;
            end
          end
          WALK: begin
            // step_busy only defers the decision; the next non-busy eval re-reads the key
            if (!kif.step_busy) begin
              if (!key_valid_q) begin
                state  <= IDLE;
                walk_q <= 1'b0;
              end else begin
                dir_q <= kdir;
              end
            end
          end
          default: begin
            state    <= IDLE;
            walk_q   <= 1'b0;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign kif.direction  = dir_q;
  assign kif.walk_req   = walk_q;
  assign kif.turn_pulse = turn_q;
  assign kif.key_valid  = key_valid_q;

endmodule

// File: doc/keycode_direction_filter.md
Name: keycode_direction_filter

Overview:
Sits between the SoC keycode register and the character movement stage. It samples the USB HID keycode once per video frame and decodes W/A/S/D into a facing direction. It applies the tap-to-turn / hold-to-walk rule: a tap only turns the character, and holding the key makes it walk. Outputs a stable direction plus a walk request to the downstream movement block. Direction is frozen while a step is in progress.

Parameters:
HOLD_FRAMES, 3, frame ticks a turned-to key must stay held before walking starts; legal range 1..15
KEY_UP, 8'h1A, HID code for W
KEY_LEFT, 8'h04, HID code for A
KEY_DOWN, 8'h16, HID code for S
KEY_RIGHT, 8'h07, HID code for D

Ports:
Clk  in  1  system clock (50 MHz domain, same clock as the SoC keycode PIO)
Reset_n  in  1  asynchronous active-low reset
keycode  in  8  current HID keycode from the SoC; 8'h00 means no key
frame_vs  in  1  VGA vertical sync (active-low pulse), asynchronous to Clk
step_busy  in  1  movement stage is mid-step; high means do not change direction or stop
direction  out  2  facing: 00 down, 01 up, 10 left, 11 right
walk_req  out  1  high while the character should keep walking
turn_pulse  out  1  one-Clk pulse when facing changes without walking
key_valid  out  1  sampled keycode is one of the four direction keys

Behaviour:
- Reset (async assert, sync release): state IDLE, direction 00, walk_req 0, turn_pulse 0, key_valid 0, hold_cnt 0, sampled key 8'h00, both frame_vs sync flops 1.
- frame_vs passes through a 2-flop synchronizer.
- tick is a single-Clk pulse on a synced 0->1 edge (end of sync); latency is 3 Clk after the pin edge.
- keycode is registered only in the tick cycle. key_valid and the decoded direction (kdir) follow one Clk later, and the FSM acts in that following cycle (eval).
- Any non-matching code, including 00, gives key_valid=0.
- States:
  - IDLE, eval with key_valid=1 and kdir==direction: go to WALK.
  - IDLE, eval with key_valid=1 and kdir!=direction: direction<=kdir, turn_pulse=1 for one Clk, hold_cnt<=1, go to TURN.
  - IDLE, key_valid=0: stay.
  - TURN, eval with the same kdir: hold_cnt+1. When the incremented value equals HOLD_FRAMES, go to WALK.
  - TURN, eval with a different valid kdir: direction<=kdir, turn_pulse, hold_cnt<=1, stay in TURN.
  - TURN, eval with key_valid=0: go to IDLE, hold_cnt<=0.
  - WALK: walk_req=1 (registered, asserted from the cycle after entry).
  - WALK, eval with step_busy=1: no change; the key is ignored and the direction is held.
  - WALK, eval with step_busy=0 and key_valid=0: walk_req<=0, go to IDLE.
  - WALK, eval with step_busy=0 and a different valid kdir: direction<=kdir with no turn_pulse; stay in WALK.
- Release while busy: a key released while step_busy=1 is re-evaluated at the first eval with step_busy=0. Do not latch a stale decision.
- Sampling: step_busy is sampled in the eval cycle itself; a same-cycle fall counts as 0.
- hold_cnt: 4 bits, saturating, cleared on leaving TURN.
- Outputs: turn_pulse is never asserted in WALK; walk_req is never asserted in IDLE or TURN.
- Reset mid-operation forces the reset values immediately, independent of Clk.

Test Plan:
- Reset_n=0 with random inputs -> direction=00, walk_req=0, turn_pulse=0, key_valid=0. Release, no frames -> outputs hold.
- keycode=8'h16 (S, already facing down) with 1 frame -> walk_req=1 after eval; no turn_pulse.
- keycode=8'h04 (A) for 1 frame then 00 -> direction=10, exactly one turn_pulse, walk_req stays 0, back to IDLE.
- keycode=8'h04 held, HOLD_FRAMES=3 -> turn_pulse at frame 1, walk_req=1 at the eval of frame 3, not before.
- WALK with step_busy=1, then keycode changed to 8'h07 and later 00 -> direction stays fixed until busy drops. At the next eval: keycode 07 gives direction=11 with walk_req=1; keycode 00 gives walk_req=0.
- frame_vs toggled asynchronously with glitch-free pulses; keycode=8'h2C (space) -> key_valid=0, state unchanged. Exactly one tick per VS pulse.
